// File: rtl/btn_pkg.sv
// Shared constants for the safe-lock button front end.
//  N_BTN        number of button channels
//  CLK_FREQ_HZ  system clock frequency; the lock FSM timing uses the same constant
//  ms_to_cycles converts a millisecond interval into a count of clk cycles
package btn_pkg;

  localparam int N_BTN       = 3;
  localparam int CLK_FREQ_HZ = 50_000_000;

  // Divide first so large clock frequencies cannot overflow the 32-bit product.
  function automatic int ms_to_cycles(input int ms, input int freq_hz = CLK_FREQ_HZ);
    return (freq_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser chain, debounce counter, clean level and
// registered press/release pulses.
//  clk               system clock
//  rstn              asynchronous active-low reset
//  btn_n_raw         raw active-low pin, asynchronous to clk
//  btn_n_clean       debounced active-low level
//  btn_n_clean_next  value btn_n_clean takes at the next edge (for registered fan-in)
//  btn_press         1-cycle pulse when the clean level falls
//  btn_release       1-cycle pulse when the clean level rises
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DB_CYC      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_n_raw,
  output logic btn_n_clean,
  output logic btn_n_clean_next,
  output logic btn_press,
  output logic btn_release
);

  localparam int CNT_W = $clog2(DB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);

  if ((DB_CYC < 1) || (SYNC_STAGES < 2)) begin : g_bad_param
    $error("btn_debounce_ch: DB_CYC must be >= 1 and SYNC_STAGES >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   s;

  // The last synchroniser stage is the first point the pin is safe to use.
  assign s = sync_q[SYNC_STAGES-1];

  // Next-state logic: shift the synchroniser and run the stability counter.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], btn_n_raw};
    cnt_d     = cnt_q;
    clean_d   = clean_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s == clean_q) begin
      // Any return to the accepted level restarts the count (bounce rejection);
      // this also parks the counter at zero while a button is held.
      cnt_d = CNT_ZERO;
    end else if (cnt_q >= CNT_LAST) begin
      // s has differed for DB_CYC consecutive edges: accept the new level.
      clean_d   = s;
      cnt_d     = CNT_ZERO;
      press_d   = ~s;
      release_d = s;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers; everything returns to the released state on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q    <= {SYNC_STAGES{1'b1}};
      cnt_q     <= CNT_ZERO;
      clean_q   <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_n_clean      = clean_q;
  assign btn_n_clean_next = clean_d;
  assign btn_press        = press_q;
  assign btn_release      = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Safe-lock button front end: N_BTN independent synchronise+debounce channels.
//  clk          system clock
//  rstn         asynchronous active-low reset
//  btn_n_raw    raw active-low pins (0 = pressed), asynchronous to clk
//  btn_n_clean  debounced active-low levels (1 = released)
//  btn_press    1-cycle pulse per channel on accepted press
//  btn_release  1-cycle pulse per channel on accepted release
//  btn_any      high while any debounced button is held
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN       = btn_pkg::N_BTN,
  parameter int CLK_FREQ_HZ = btn_pkg::CLK_FREQ_HZ,
  parameter int DEBOUNCE_MS = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_BTN-1:0] btn_n_raw,
  output logic [N_BTN-1:0] btn_n_clean,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             btn_any
);

  localparam int DB_CYC = ms_to_cycles(DEBOUNCE_MS, CLK_FREQ_HZ);

  if ((DB_CYC < 1) || (SYNC_STAGES < 2)) begin : g_bad_param
    $error("btn_conditioner: DB_CYC must be >= 1 and SYNC_STAGES >= 2");
  end

  logic [N_BTN-1:0] clean_next;
  logic             any_q, any_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYC      (DB_CYC),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk              (clk),
      .rstn             (rstn),
      .btn_n_raw        (btn_n_raw[i]),
      .btn_n_clean      (btn_n_clean[i]),
      .btn_n_clean_next (clean_next[i]),
      .btn_press        (btn_press[i]),
      .btn_release      (btn_release[i])
    );
  end

  // Built from the channels' next clean value so the registered flag tracks
  // btn_n_clean on the same edge.
  always_comb begin
    any_d = |(~clean_next);
  end

  // Registered any-button-held flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      any_q <= 1'b0;
    end else begin
      any_q <= any_d;
    end
  end

  assign btn_any = any_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner at CLK_FREQ_HZ=1000, DEBOUNCE_MS=4 (DB_CYC=4), SYNC_STAGES=2.
// Inputs change 2 ns after a rising edge; outputs are checked on the falling edge.
// "Edge E" below is the rising edge just before the raw change, so the pin is
// first sampled at E+1 and the debounced level changes at E+6.
module tb_btn_conditioner;

  localparam int NB    = 3;
  localparam int SS    = 2;
  localparam int DB    = 4;
  localparam int DEPTH = SS + DB - 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [NB-1:0] btn_n_raw = 3'b111;
  logic [NB-1:0] btn_n_clean, btn_press, btn_release;
  logic          btn_any;

  int n_cmp = 0;
  int n_bad = 0;
  int press_cnt [NB];
  int rel_cnt [NB];

  btn_conditioner #(
    .N_BTN       (NB),
    .CLK_FREQ_HZ (1000),
    .DEBOUNCE_MS (4),
    .SYNC_STAGES (SS)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .btn_n_raw   (btn_n_raw),
    .btn_n_clean (btn_n_clean),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_any     (btn_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. rq[k] holds the raw value sampled k+1 edges ago. The
  // synchronised value seen at an edge is the raw value from SS edges earlier,
  // and a level is accepted once DB consecutive synchronised samples all
  // disagree with the current clean level.
  logic [NB-1:0] rq [DEPTH];
  logic [NB-1:0] m_clean = 3'b111;
  logic [NB-1:0] m_press = 3'b000;
  logic [NB-1:0] m_rel   = 3'b000;

  always @(posedge clk) begin : model
    logic [NB-1:0] nc, np, nr;
    logic          all_diff;
    if (!rstn) begin
      for (int k = 0; k < DEPTH; k++) rq[k] <= 3'b111;
      m_clean <= 3'b111;
      m_press <= 3'b000;
      m_rel   <= 3'b000;
    end else begin
      nc = m_clean;
      np = 3'b000;
      nr = 3'b000;
      for (int ch = 0; ch < NB; ch++) begin
        all_diff = 1'b1;
        for (int k = SS - 1; k < DEPTH; k++) begin
          if (rq[k][ch] == m_clean[ch]) all_diff = 1'b0;
        end
        if (all_diff) begin
          nc[ch] = ~m_clean[ch];
          np[ch] = m_clean[ch];
          nr[ch] = ~m_clean[ch];
        end
      end
      for (int k = DEPTH - 1; k > 0; k--) rq[k] <= rq[k-1];
      rq[0]   <= btn_n_raw;
      m_clean <= nc;
      m_press <= np;
      m_rel   <= nr;
    end
  end

  // Every-cycle comparison against the model (reset values while rstn is low).
  always @(negedge clk) begin : compare
    logic [NB-1:0] e_clean, e_press, e_rel;
    logic          e_any;
    if (!rstn) begin
      e_clean = 3'b111;
      e_press = 3'b000;
      e_rel   = 3'b000;
      e_any   = 1'b0;
    end else begin
      e_clean = m_clean;
      e_press = m_press;
      e_rel   = m_rel;
      e_any   = |(~m_clean);
    end
    check("clean", 32'(btn_n_clean), 32'(e_clean));
    check("press", 32'(btn_press), 32'(e_press));
    check("release", 32'(btn_release), 32'(e_rel));
    check("any", 32'(btn_any), 32'(e_any));
    for (int ch = 0; ch < NB; ch++) begin
      press_cnt[ch] = press_cnt[ch] + int'(btn_press[ch]);
      rel_cnt[ch]   = rel_cnt[ch] + int'(btn_release[ch]);
    end
  end

  task automatic drive(input logic [NB-1:0] v);
    @(posedge clk);
    #2 btn_n_raw = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Advance n rising edges, then stop at the following falling edge.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    for (int ch = 0; ch < NB; ch++) begin
      press_cnt[ch] = 0;
      rel_cnt[ch]   = 0;
    end
  endtask

  initial begin
    logic [NB-1:0] v;
    int            rate;
    clear_counts();
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    idle(10);

    // 1: clean press on channel 0
    clear_counts();
    drive(3'b110);
    wait_edges(5);
    check("t1_clean_e5", 32'(btn_n_clean), 32'h7);
    check("t1_press_e5", 32'(btn_press), 32'h0);
    wait_edges(1);
    check("t1_clean_e6", 32'(btn_n_clean), 32'h6);
    check("t1_press_e6", 32'(btn_press), 32'h1);
    check("t1_any_e6", 32'(btn_any), 32'h1);
    wait_edges(1);
    check("t1_press_e7", 32'(btn_press), 32'h0);
    drive(3'b111);
    idle(12);
    check("t1_press_count", 32'(press_cnt[0]), 32'd1);
    check("t1_release_count", 32'(rel_cnt[0]), 32'd1);

    // 2: 3-cycle bounce on channel 1 is rejected
    clear_counts();
    drive(3'b101);
    drive(3'b101);
    drive(3'b101);
    drive(3'b111);
    idle(12);
    check("t2_clean", 32'(btn_n_clean), 32'h7);
    check("t2_press_count", 32'(press_cnt[1]), 32'd0);

    // 3: bounce then settle on channel 1
    clear_counts();
    drive(3'b101);
    drive(3'b101);
    drive(3'b101);
    drive(3'b111);
    drive(3'b101);
    wait_edges(5);
    check("t3_clean_e5", 32'(btn_n_clean), 32'h7);
    wait_edges(1);
    check("t3_clean_e6", 32'(btn_n_clean), 32'h5);
    check("t3_press_e6", 32'(btn_press), 32'h2);
    idle(10);
    check("t3_press_count", 32'(press_cnt[1]), 32'd1);
    drive(3'b111);
    idle(12);

    // 4: long hold and release on channel 2
    clear_counts();
    drive(3'b011);
    idle(100);
    check("t4_held_clean", 32'(btn_n_clean), 32'h3);
    drive(3'b111);
    wait_edges(5);
    check("t4_release_e5", 32'(btn_release), 32'h0);
    wait_edges(1);
    check("t4_release_e6", 32'(btn_release), 32'h4);
    check("t4_clean_e6", 32'(btn_n_clean), 32'h7);
    check("t4_any_e6", 32'(btn_any), 32'h0);
    idle(5);
    check("t4_press_count", 32'(press_cnt[2]), 32'd1);
    check("t4_release_count", 32'(rel_cnt[2]), 32'd1);

    // 5: simultaneous press on channels 0 and 1
    clear_counts();
    drive(3'b100);
    wait_edges(6);
    check("t5_press", 32'(btn_press), 32'h3);
    check("t5_clean", 32'(btn_n_clean), 32'h4);
    check("t5_any", 32'(btn_any), 32'h1);
    wait_edges(1);
    check("t5_press_next", 32'(btn_press), 32'h0);
    drive(3'b111);
    idle(12);

    // 6: reset while channel 0 is mid-count, pin still held afterwards
    clear_counts();
    drive(3'b110);
    wait_edges(4);
    rstn = 1'b0;
    #1;
    check("t6_clean_rst", 32'(btn_n_clean), 32'h7);
    check("t6_any_rst", 32'(btn_any), 32'h0);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    wait_edges(5);
    check("t6_press_e5", 32'(btn_press), 32'h0);
    wait_edges(1);
    check("t6_press_e6", 32'(btn_press), 32'h1);
    check("t6_clean_e6", 32'(btn_n_clean), 32'h6);
    drive(3'b111);
    idle(12);

    // Random bouncing pins, alternating noisy and calm phases, with occasional resets.
    v = 3'b111;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rate = ((cyc / 200) % 2 == 0) ? 3 : 20;
      for (int ch = 0; ch < NB; ch++) begin
        if ($urandom_range(0, rate - 1) == 0) v[ch] = ~v[ch];
      end
      drive(v);
      if ($urandom_range(0, 599) == 0) begin
        rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
      end
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
